reg_frame_ctrl: RTL and testbench

Front-end command parser that sits directly upstream of the register bank of rw_reg instances. It accepts a byte stream of write/read command frames and checks a CRC-8 over each frame. It issues single-cycle write or read strobes with address, data and CRC to the bank, then returns a response byte stream: ACK/NACK for writes, read data plus stored CRC for reads. The bank's o_rdata/o_rcrc outputs are OR-combined outside this block and fed back on i_rdata/i_rcrc.

---
 rtl/reg_frame_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_reg_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_frame_ctrl.sv
// Command-frame parser in front of the rw_reg bank: decodes write/read frames,
// checks a CRC-8 over each frame, issues one-cycle bank strobes and returns a
// response byte stream (ACK/NACK for writes, data + stored CRC for reads).
module reg_frame_ctrl #(
    parameter int unsigned DW          = 8,
    parameter int unsigned AW          = 8,
    parameter int unsigned CRC_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_vld,
    input  logic [7:0]       i_rx_data,
    output logic             o_rx_rdy,
    output logic             o_wen,
    output logic             o_ren,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_wdata,
    output logic [CRC_W-1:0] o_crc_data,
    input  logic [DW-1:0]    i_rdata,
    input  logic [CRC_W-1:0] i_rcrc,
    output logic             o_rsp_vld,
    output logic [7:0]       o_rsp_data,
    input  logic             i_rsp_rdy,
    output logic             o_timeout
);

    localparam logic [7:0] CmdWr    = 8'h5A;
    localparam logic [7:0] CmdRd    = 8'hA5;
    localparam logic [7:0] RspAck   = 8'hAC;
    localparam logic [7:0] RspCrcEr = 8'hE1;
    localparam logic [7:0] RspCmdEr = 8'hE2;
    // Counter value at which the next idle cycle aborts the frame.
    localparam logic [7:0] TmoLast  = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StCrc,
        StExec,
        StRsp0,
        StRsp1
    } state_e;

    state_e           state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic [7:0]       crc_q, crc_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CRC_W-1:0] crc_data_q, crc_data_d;
    logic [7:0]       rsp0_q, rsp0_d;
    logic [7:0]       rsp1_q, rsp1_d;
    logic             wen_q, wen_d;
    logic             ren_q, ren_d;
    logic             tmo_q, tmo_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rx_fire;

    // CRC-8, poly 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Ready and response outputs decoded from the current state.
    always_comb begin
        o_rx_rdy   = (state_q == StIdle) || (state_q == StAddr) ||
                     (state_q == StData) || (state_q == StCrc);
        o_rsp_vld  = (state_q == StRsp0) || (state_q == StRsp1);
        o_rsp_data = 8'h00;
        if (state_q == StRsp0) begin
            o_rsp_data = rsp0_q;
        end else if (state_q == StRsp1) begin
            o_rsp_data = rsp1_q;
        end
    end

    assign rx_fire    = i_rx_vld && o_rx_rdy;
    assign o_wen      = wen_q;
    assign o_ren      = ren_q;
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_crc_data = crc_data_q;
    assign o_timeout  = tmo_q;

    // Next-state logic: frame parsing, strobes, responses and inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        crc_d      = crc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        crc_data_d = crc_data_q;
        rsp0_d     = rsp0_q;
        rsp1_d     = rsp1_q;
        wen_d      = 1'b0;
        ren_d      = 1'b0;
        tmo_d      = 1'b0;
        cnt_d      = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    crc_d = crc8_upd(8'h00, i_rx_data);
                    if (i_rx_data == CmdWr) begin
                        is_wr_d = 1'b1;
                        state_d = StAddr;
                    end else if (i_rx_data == CmdRd) begin
                        is_wr_d = 1'b0;
                        state_d = StAddr;
                    end else begin
                        rsp1_d  = RspCmdEr;
                        state_d = StRsp1;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d  = AW'(i_rx_data);
                    crc_d   = crc8_upd(crc_q, i_rx_data);
                    state_d = is_wr_q ? StData : StCrc;
                end
            end
            StData: begin
                if (rx_fire) begin
                    wdata_d = DW'(i_rx_data);
                    crc_d   = crc8_upd(crc_q, i_rx_data);
                    state_d = StCrc;
                end
            end
            StCrc: begin
                if (rx_fire) begin
                    crc_data_d = CRC_W'(i_rx_data);
                    if (i_rx_data == crc_q) begin
                        wen_d   = is_wr_q;
                        ren_d   = !is_wr_q;
                        state_d = StExec;
                    end else begin
                        rsp1_d  = RspCrcEr;
                        state_d = StRsp1;
                    end
                end
            end
            StExec: begin
                if (is_wr_q) begin
                    rsp1_d  = RspAck;
                    state_d = StRsp1;
                end else begin
                    // Bank read data is only valid while the read strobe is high.
                    rsp0_d  = 8'(i_rdata);
                    rsp1_d  = 8'(i_rcrc);
                    state_d = StRsp0;
                end
            end
            StRsp0: begin
                if (i_rsp_rdy) begin
                    state_d = StRsp1;
                end
            end
            StRsp1: begin
                if (i_rsp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort a stalled frame; overrides the parse result above.
        if (((state_q == StAddr) || (state_q == StData) || (state_q == StCrc)) && !rx_fire) begin
            if (cnt_q == TmoLast) begin
                state_d = StIdle;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            is_wr_q    <= 1'b0;
            crc_q      <= 8'h00;
            addr_q     <= '0;
            wdata_q    <= '0;
            crc_data_q <= '0;
            rsp0_q     <= 8'h00;
            rsp1_q     <= 8'h00;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            crc_q      <= crc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            crc_data_q <= crc_data_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_frame_ctrl.sv
// Directed bench for reg_frame_ctrl: write, read, CRC error, bad command with
// backpressure, inter-byte timeout and mid-frame reset.
module tb_reg_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_vld;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       wen;
    logic       ren;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] crc_data;
    logic [7:0] rdata;
    logic [7:0] rcrc;
    logic       rsp_vld;
    logic [7:0] rsp_data;
    logic       rsp_rdy;
    logic       timeout;

    logic [7:0] bank_rdata;
    logic [7:0] bank_rcrc;

    int n_checks;
    int n_fail;
    int wen_cnt;
    int ren_cnt;
    int both_cnt;
    int tmo_cnt;
    int wen_base;
    int ren_base;

    reg_frame_ctrl #(
        .DW          (8),
        .AW          (8),
        .CRC_W       (8),
        .TIMEOUT_CYC (4)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_vld   (rx_vld),
        .i_rx_data  (rx_data),
        .o_rx_rdy   (rx_rdy),
        .o_wen      (wen),
        .o_ren      (ren),
        .o_addr     (addr),
        .o_wdata    (wdata),
        .o_crc_data (crc_data),
        .i_rdata    (rdata),
        .i_rcrc     (rcrc),
        .o_rsp_vld  (rsp_vld),
        .o_rsp_data (rsp_data),
        .i_rsp_rdy  (rsp_rdy),
        .o_timeout  (timeout)
    );

    // Bank model: OR-combined bus is zero unless the bank is read.
    assign rdata = ren ? bank_rdata : 8'h00;
    assign rcrc  = ren ? bank_rcrc  : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe and timeout event counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wen) wen_cnt++;
            if (ren) ren_cnt++;
            if (wen && ren) both_cnt++;
            if (timeout) tmo_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        check_eq({tag, "_rdy"}, 32'(rx_rdy), 32'd1);
        rx_vld  = 1'b1;
        rx_data = b;
        step();
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    // Bounded wait for a response byte; consumed at the following edge.
    task automatic expect_rsp(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (rsp_vld) break;
            step();
        end
        check_eq({tag, "_vld"}, 32'(rsp_vld), 32'd1);
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        wen_cnt    = 0;
        ren_cnt    = 0;
        both_cnt   = 0;
        tmo_cnt    = 0;
        rst_n      = 1'b0;
        rx_vld     = 1'b0;
        rx_data    = 8'h00;
        rsp_rdy    = 1'b1;
        bank_rdata = 8'h3C;
        bank_rcrc  = 8'h40;
        step();
        step();
        rst_n = 1'b1;

        // Reset state.
        check_eq("rst_rdy", 32'(rx_rdy), 32'd1);
        check_eq("rst_wen", 32'(wen), 32'd0);
        check_eq("rst_ren", 32'(ren), 32'd0);
        check_eq("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);

        // Write OK: CRC8(5A,10,3C) = 0x40.
        wen_base = wen_cnt;
        send_byte("wr_cmd", 8'h5A);
        send_byte("wr_addr", 8'h10);
        send_byte("wr_data", 8'h3C);
        send_byte("wr_crc", 8'h40);
        check_eq("wr_wen", 32'(wen), 32'd1);
        check_eq("wr_ren", 32'(ren), 32'd0);
        check_eq("wr_addr_out", 32'(addr), 32'h10);
        check_eq("wr_wdata_out", 32'(wdata), 32'h3C);
        check_eq("wr_crc_out", 32'(crc_data), 32'h40);
        check_eq("wr_rx_rdy", 32'(rx_rdy), 32'd0);
        step();
        check_eq("wr_wen_off", 32'(wen), 32'd0);
        check_eq("wr_addr_hold", 32'(addr), 32'h10);
        expect_rsp("wr_ack", 8'hAC);
        check_eq("wr_wen_count", 32'(wen_cnt - wen_base), 32'd1);

        // Read OK: CRC8(A5,10) = 0x29.
        ren_base = ren_cnt;
        send_byte("rd_cmd", 8'hA5);
        send_byte("rd_addr", 8'h10);
        send_byte("rd_crc", 8'h29);
        check_eq("rd_ren", 32'(ren), 32'd1);
        check_eq("rd_wen", 32'(wen), 32'd0);
        check_eq("rd_addr_out", 32'(addr), 32'h10);
        step();
        check_eq("rd_ren_off", 32'(ren), 32'd0);
        expect_rsp("rd_data", 8'h3C);
        expect_rsp("rd_rcrc", 8'h40);
        check_eq("rd_ren_count", 32'(ren_cnt - ren_base), 32'd1);

        // CRC error: received CRC is latched but no strobe.
        wen_base = wen_cnt;
        send_byte("ce_cmd", 8'h5A);
        send_byte("ce_addr", 8'h10);
        send_byte("ce_data", 8'h3C);
        send_byte("ce_crc", 8'h41);
        check_eq("ce_wen", 32'(wen), 32'd0);
        check_eq("ce_crc_out", 32'(crc_data), 32'h41);
        expect_rsp("ce_nack", 8'hE1);
        check_eq("ce_wen_count", 32'(wen_cnt - wen_base), 32'd0);

        // Bad command held under backpressure.
        rsp_rdy = 1'b0;
        send_byte("bc_cmd", 8'h33);
        for (int i = 0; i < 5; i++) begin
            check_eq("bc_hold_vld", 32'(rsp_vld), 32'd1);
            check_eq("bc_hold_data", 32'(rsp_data), 32'hE2);
            check_eq("bc_hold_rdy", 32'(rx_rdy), 32'd0);
            step();
        end
        rsp_rdy = 1'b1;
        expect_rsp("bc_rel", 8'hE2);
        check_eq("bc_idle_rdy", 32'(rx_rdy), 32'd1);

        // Timeout after 4 idle cycles in DATA.
        wen_base = wen_cnt;
        send_byte("to_cmd", 8'h5A);
        send_byte("to_addr", 8'h10);
        step();
        step();
        step();
        check_eq("to_early", 32'(timeout), 32'd0);
        step();
        check_eq("to_pulse", 32'(timeout), 32'd1);
        check_eq("to_idle_rdy", 32'(rx_rdy), 32'd1);
        check_eq("to_rsp_vld", 32'(rsp_vld), 32'd0);
        step();
        check_eq("to_pulse_end", 32'(timeout), 32'd0);
        check_eq("to_wen_count", 32'(wen_cnt - wen_base), 32'd0);
        ren_base = ren_cnt;
        send_byte("to_rd_cmd", 8'hA5);
        send_byte("to_rd_addr", 8'h10);
        send_byte("to_rd_crc", 8'h29);
        check_eq("to_rd_ren", 32'(ren), 32'd1);
        step();
        expect_rsp("to_rd_data", 8'h3C);
        expect_rsp("to_rd_rcrc", 8'h40);
        check_eq("to_ren_count", 32'(ren_cnt - ren_base), 32'd1);
        check_eq("to_total", 32'(tmo_cnt), 32'd1);

        // Reset mid-frame.
        wen_base = wen_cnt;
        send_byte("mr_cmd", 8'h5A);
        send_byte("mr_addr", 8'h10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mr_rdy", 32'(rx_rdy), 32'd1);
        check_eq("mr_wen", 32'(wen), 32'd0);
        check_eq("mr_ren", 32'(ren), 32'd0);
        check_eq("mr_addr", 32'(addr), 32'd0);
        check_eq("mr_wdata", 32'(wdata), 32'd0);
        check_eq("mr_crc", 32'(crc_data), 32'd0);
        check_eq("mr_rsp_vld", 32'(rsp_vld), 32'd0);
        check_eq("mr_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("mr_timeout", 32'(timeout), 32'd0);
        send_byte("mr_b3c", 8'h3C);
        expect_rsp("mr_b3c_rsp", 8'hE2);
        send_byte("mr_b40", 8'h40);
        expect_rsp("mr_b40_rsp", 8'hE2);
        check_eq("mr_wen_count", 32'(wen_cnt - wen_base), 32'd0);
        check_eq("both_strobes", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
